// File: rtl/data_mem_responder_if.sv
// Load/store bus between the core's EX/MEM stage and the data-memory responder.
// The core drives address and store data every cycle; load data returns combinationally.
interface data_mem_responder_if;
  logic [31:0] addr;
  logic        w_en;
  logic [31:0] w_data;
  logic [31:0] r_data;

  modport master (output addr, output w_en, output w_data, input r_data);
  modport slave  (input addr, input w_en, input w_data, output r_data);
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder: word RAM plus a memory-mapped register block
// (64-bit cycle counter, timer compare/irq, GPIO output, sticky error flag).
module data_mem_responder #(
  parameter int DEPTH  = 1024,
  parameter int GPIO_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  data_mem_responder_if.slave   bus,
  output logic [GPIO_W-1:0]     gpio_out,
  output logic                  irq,
  output logic                  err
);

  localparam int          AW        = $clog2(DEPTH);
  localparam int          NREG      = 5;
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH * 4);

  localparam int REG_CYC_LO = 0;
  localparam int REG_CYC_HI = 1;
  localparam int REG_TCMP   = 2;
  localparam int REG_GPIO   = 3;
  localparam int REG_STATUS = 4;

  logic [31:0] mem [DEPTH];

  logic [63:0]       cnt_q, cnt_d;
  logic [31:0]       timecmp_q, timecmp_d;
  logic [GPIO_W-1:0] gpio_q, gpio_d;
  logic              irq_q, irq_d;
  logic              err_q, err_d;

  logic            ram_hit;
  logic            reg_region;
  logic [NREG-1:0] reg_hit;
  logic [AW-1:0]   ram_idx;
  logic            aligned;
  logic            wr_ok;
  logic            ram_we, tcmp_we, gpio_we, stat_we;
  logic            wr_err;
  logic [31:0]     rdata_c;

  // Register block occupies 0x8000_0000..0x8000_001F; only the first five words exist.
  assign reg_region = (bus.addr[31:5] == 27'h400_0000);
  assign ram_hit    = (bus.addr < RAM_BYTES);
  assign ram_idx    = bus.addr[AW+1:2];
  assign aligned    = (bus.addr[1:0] == 2'b00);

  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_reg_dec
      assign reg_hit[gi] = reg_region && (bus.addr[4:2] == 3'(gi));
    end
  endgenerate

  // Any write that lands nowhere writable is an error; this covers misalignment,
  // unmapped space and the read-only counter words in one place.
  assign wr_ok   = bus.w_en && aligned;
  assign ram_we  = wr_ok && ram_hit;
  assign tcmp_we = wr_ok && reg_hit[REG_TCMP];
  assign gpio_we = wr_ok && reg_hit[REG_GPIO];
  assign stat_we = wr_ok && reg_hit[REG_STATUS];
  assign wr_err  = bus.w_en && !(ram_we || tcmp_we || gpio_we || stat_we);

  always_comb begin
    rdata_c = '0;
    if (ram_hit)                      rdata_c = mem[ram_idx];
    else if (reg_hit[REG_CYC_LO])     rdata_c = cnt_q[31:0];
    else if (reg_hit[REG_CYC_HI])     rdata_c = cnt_q[63:32];
    else if (reg_hit[REG_TCMP])       rdata_c = timecmp_q;
    else if (reg_hit[REG_GPIO])       rdata_c = 32'(gpio_q);
    else if (reg_hit[REG_STATUS])     rdata_c = {30'b0, err_q, irq_q};
  end

  assign bus.r_data = rdata_c;

  always_comb begin
    cnt_d     = cnt_q + 64'd1;
    timecmp_d = timecmp_q;
    gpio_d    = gpio_q;
    irq_d     = irq_q;
    err_d     = err_q;

    if (tcmp_we) timecmp_d = bus.w_data;
    if (gpio_we) gpio_d    = bus.w_data[GPIO_W-1:0];

    // A compare write beats a coincident match and re-arms the timer.
    if (tcmp_we)                            irq_d = 1'b0;
    else if (cnt_q[31:0] == timecmp_q)      irq_d = 1'b1;

    if (wr_err)                             err_d = 1'b1;
    else if (stat_we && bus.w_data[1])      err_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      timecmp_q <= 32'hFFFF_FFFF;
      gpio_q    <= '0;
      irq_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timecmp_q <= timecmp_d;
      gpio_q    <= gpio_d;
      irq_q     <= irq_d;
      err_q     <= err_d;
    end
  end

  // RAM is never cleared, but stores are blocked while reset is held.
  always_ff @(posedge clk) begin
    if (rst_n && ram_we) mem[ram_idx] <= bus.w_data;
  end

  assign gpio_out = gpio_q;
  assign irq      = irq_q;
  assign err      = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: stimulus queues expected values,
// a negedge monitor pops and compares them.
module tb_data_mem_responder;

  localparam int DEPTH  = 1024;
  localparam int GPIO_W = 8;

  localparam logic [31:0] A_CYC_LO = 32'h8000_0000;
  localparam logic [31:0] A_CYC_HI = 32'h8000_0004;
  localparam logic [31:0] A_TCMP   = 32'h8000_0008;
  localparam logic [31:0] A_GPIO   = 32'h8000_000C;
  localparam logic [31:0] A_STATUS = 32'h8000_0010;

  localparam int S_RDATA = 0;
  localparam int S_GPIO  = 1;
  localparam int S_IRQ   = 2;
  localparam int S_ERR   = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic [GPIO_W-1:0] gpio_out;
  logic irq, err;

  data_mem_responder_if bus ();

  data_mem_responder #(.DEPTH(DEPTH), .GPIO_W(GPIO_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus.slave),
    .gpio_out (gpio_out),
    .irq      (irq),
    .err      (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned cyc;
    int          sel;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t        q [$];
  int unsigned cyc = 0;
  int unsigned k;
  int          n_checks = 0;
  int          n_fail   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Edges since reset release: the value CYCLE_LO must show in the current cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) k <= 0;
    else        k <= k + 1;
  end

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      logic [31:0] act;
      e = q.pop_front();
      case (e.sel)
        S_RDATA: act = bus.r_data;
        S_GPIO:  act = 32'(gpio_out);
        S_IRQ:   act = {31'b0, irq};
        default: act = {31'b0, err};
      endcase
      n_checks++;
      if (e.cyc != cyc || act !== e.val) begin
        n_fail++;
        $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d, sampled %0d)",
                 e.name, act, e.val, e.cyc, cyc);
      end else begin
        $display("check %s = 0x%08h", e.name, act);
      end
    end
  end

  task automatic drive(input logic [31:0] a, input logic we, input logic [31:0] d);
    bus.addr   = a;
    bus.w_en   = we;
    bus.w_data = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int sel, input logic [31:0] val, input string name);
    exp_t e;
    e.cyc  = cyc;
    e.sel  = sel;
    e.val  = val;
    e.name = name;
    q.push_back(e);
  endtask

  initial begin
    int unsigned t_cmp;
    int          guard;
    rst_n = 1'b0;
    drive(32'h0, 1'b0, 32'h0);
    tick();

    // Held in reset
    drive(A_CYC_HI, 1'b0, 32'h0);
    push_exp(S_GPIO, 32'h0, "rst_gpio");
    push_exp(S_IRQ,  32'h0, "rst_irq");
    push_exp(S_ERR,  32'h0, "rst_err");
    push_exp(S_RDATA, 32'h0, "rst_cyc_hi");
    tick();
    drive(A_TCMP, 1'b0, 32'h0);
    push_exp(S_RDATA, 32'hFFFF_FFFF, "rst_timecmp");
    @(negedge clk);
    #1 rst_n = 1'b1;
    tick();
    drive(A_CYC_LO, 1'b0, 32'h0);
    push_exp(S_RDATA, 32'd1, "cycle_lo_edge1");
    tick();
    push_exp(S_RDATA, 32'd2, "cycle_lo_edge2");
    tick();

    // Write latency: same-cycle read returns old value
    drive(32'h10, 1'b1, 32'h1111_1111);
    tick();
    drive(32'h10, 1'b1, 32'hDEAD_BEEF);
    push_exp(S_RDATA, 32'h1111_1111, "same_cycle_old");
    push_exp(S_GPIO, 32'h0, "t1_gpio");
    push_exp(S_IRQ,  32'h0, "t1_irq");
    push_exp(S_ERR,  32'h0, "t1_err");
    tick();
    drive(32'h10, 1'b0, 32'h0);
    push_exp(S_RDATA, 32'hDEAD_BEEF, "next_cycle_new");
    push_exp(S_ERR,  32'h0, "t1_err_after");
    tick();

    // Back-to-back writes then reads
    drive(32'h0, 1'b1, 32'hA0A0_0001); tick();
    drive(32'h4, 1'b1, 32'hB0B0_0002); tick();
    drive(32'h8, 1'b1, 32'hC0C0_0003); tick();
    drive(32'h0, 1'b0, 32'h0); push_exp(S_RDATA, 32'hA0A0_0001, "b2b_w0"); tick();
    drive(32'h4, 1'b0, 32'h0); push_exp(S_RDATA, 32'hB0B0_0002, "b2b_w1"); tick();
    drive(32'h8, 1'b0, 32'h0); push_exp(S_RDATA, 32'hC0C0_0003, "b2b_w2"); tick();
    drive(32'h0, 1'b1, 32'h5555_AAAA); tick();
    drive(32'h2, 1'b0, 32'h0);
    push_exp(S_RDATA, 32'h5555_AAAA, "misaligned_read");
    push_exp(S_ERR, 32'h0, "misaligned_read_err");
    tick();

    // Error writes are dropped and set err
    drive(32'h2, 1'b1, 32'h1234);
    tick();
    drive(32'(DEPTH * 4), 1'b1, 32'h1234);
    push_exp(S_ERR, 32'h1, "err_after_misaligned");
    push_exp(S_RDATA, 32'h0, "unmapped_read_zero");
    tick();
    drive(A_CYC_LO, 1'b1, 32'h1234);
    push_exp(S_RDATA, k, "cycle_lo_write_dropped");
    tick();
    drive(A_STATUS, 1'b0, 32'h0);
    push_exp(S_RDATA, 32'h2, "status_err");
    tick();
    drive(32'h0, 1'b0, 32'h0);
    push_exp(S_RDATA, 32'h5555_AAAA, "ram0_untouched");
    tick();
    drive(A_STATUS, 1'b1, 32'h2);
    push_exp(S_ERR, 32'h1, "err_before_clear");
    tick();
    drive(A_STATUS, 1'b0, 32'h0);
    push_exp(S_ERR, 32'h0, "err_cleared");
    push_exp(S_RDATA, 32'h0, "status_clear");
    tick();

    // Timer: compare written 15 ahead of the current count
    t_cmp = k + 15;
    drive(A_TCMP, 1'b1, t_cmp);
    tick();
    for (int i = 0; i < 20; i++) begin
      drive(A_CYC_LO, 1'b0, 32'h0);
      push_exp(S_RDATA, k, "timer_cycle_lo");
      push_exp(S_IRQ, {31'b0, (k >= t_cmp + 1)}, "timer_irq");
      tick();
    end
    drive(A_TCMP, 1'b1, 32'hFFFF_FFFF);
    push_exp(S_IRQ, 32'h1, "irq_held");
    tick();
    drive(A_TCMP, 1'b0, 32'h0);
    push_exp(S_IRQ, 32'h0, "irq_cleared_by_write");
    push_exp(S_RDATA, 32'hFFFF_FFFF, "timecmp_readback");
    tick();

    // Timecmp rewritten in the very cycle of the match
    t_cmp = k + 4;
    drive(A_TCMP, 1'b1, t_cmp);
    tick();
    guard = 0;
    while (k != t_cmp && guard < 10) begin
      drive(A_CYC_LO, 1'b0, 32'h0);
      push_exp(S_IRQ, 32'h0, "pre_match_irq");
      tick();
      guard++;
    end
    drive(A_TCMP, 1'b1, 32'hFFFF_FFFF);
    push_exp(S_RDATA, t_cmp, "match_cycle_timecmp");
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(A_CYC_LO, 1'b0, 32'h0);
      push_exp(S_IRQ, 32'h0, "write_wins_irq");
      tick();
    end

    // Arm irq and err, set GPIO, then reset mid-cycle
    drive(A_TCMP, 1'b1, k + 2);
    tick();
    drive(32'h0, 1'b0, 32'h0);
    tick();
    tick();
    drive(A_CYC_HI, 1'b1, 32'h0);
    push_exp(S_IRQ, 32'h1, "irq_armed");
    tick();
    drive(A_GPIO, 1'b1, 32'h1FF);
    push_exp(S_ERR, 32'h1, "err_cyc_hi_write");
    push_exp(S_GPIO, 32'h0, "gpio_before_edge");
    tick();
    drive(A_GPIO, 1'b0, 32'h0);
    push_exp(S_GPIO, 32'hFF, "gpio_out_trunc");
    push_exp(S_RDATA, 32'hFF, "gpio_readback");
    tick();
    drive(A_CYC_LO, 1'b0, 32'h0);
    #2 rst_n = 1'b0;
    push_exp(S_GPIO, 32'h0, "async_rst_gpio");
    push_exp(S_IRQ,  32'h0, "async_rst_irq");
    push_exp(S_ERR,  32'h0, "async_rst_err");
    push_exp(S_RDATA, 32'h0, "async_rst_cycle");
    tick();
    drive(32'h10, 1'b1, 32'h0BAD_0BAD);
    push_exp(S_RDATA, 32'hDEAD_BEEF, "ram_kept_in_reset");
    tick();
    drive(32'h10, 1'b0, 32'h0);
    push_exp(S_RDATA, 32'hDEAD_BEEF, "write_ignored_in_reset");
    tick();
    drive(A_CYC_LO, 1'b0, 32'h0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    tick();
    push_exp(S_RDATA, 32'd1, "cycle_lo_after_rerelease");
    tick();
    tick();

    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Data-memory responder on the core's load/store port: answers the address/write-enable/write-data/read-data interface driven from the core's EX/MEM stage. It holds a word-addressed RAM plus a small memory-mapped register block containing a 64-bit cycle counter, a timer compare with interrupt, a GPIO output register, and a sticky access-error flag. Reads are combinational so the core can capture load data into MEM/WB at the same edge; writes commit on the clock edge.

## Interface
- DEPTH, 1024, RAM size in 32-bit words; power of two, at least 2
- GPIO_W, 8, width of gpio_out; 1..32
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low; one clock; reset is asynchronous and active-low
- addr  in  32  byte address of the access, valid every cycle
- w_en  in  1  write strobe for the current cycle
- w_data  in  32  store data
- r_data  out  32  load data, combinational from addr and current state
- gpio_out  out  GPIO_W  GPIO register, registered
- irq  out  1  timer interrupt, registered, level
- err  out  1  sticky access error, registered

## Operation
- Address map:
  - addr[31]=0 and addr < DEPTH*4: RAM word addr[log2(DEPTH)+1:2].
  - 0x8000_0000 CYCLE_LO (RO).
  - 0x8000_0004 CYCLE_HI (RO).
  - 0x8000_0008 TIMECMP (RW).
  - 0x8000_000C GPIO (RW, low GPIO_W bits; upper bits read 0).
  - 0x8000_0010 STATUS (bit0 = irq, bit1 = err; write with w_data[1]=1 clears err, other bits ignored).
- Error access, with w_en=1:
  - addr[1:0] != 0;
  - addr[31]=0 and addr >= DEPTH*4;
  - addr[31]=1 with any address outside the five registers;
  - a write to CYCLE_LO or CYCLE_HI.
  - An error write is dropped and sets err.
- Reads never set err:
  - misaligned reads use addr with bits [1:0] ignored;
  - unmapped reads return 0.
- RAM: never reset; contents undefined until written.
- Cycle counter: 64-bit, +1 every cycle, wraps 2^64-1 -> 0.
  - CYCLE_HI reads live bits [63:32]; no snapshot. Software re-reads on carry.
- Timer: irq is set when counter[31:0] == TIMECMP (32-bit compare). irq stays set until TIMECMP is written.
- Widths: all registers are 32-bit except the counter (64) and GPIO (GPIO_W). Writes to GPIO truncate w_data.

## Timing
- Reset values: r_data follows the map (RAM undefined; CYCLE_LO/CYCLE_HI read 0), gpio_out=0, irq=0, err=0, counter=0, TIMECMP=0xFFFF_FFFF.
- rst_n low mid-operation: all registers clear immediately and w_en is ignored while low. RAM keeps its contents.
- Read latency 0: r_data is valid in the same cycle as addr.
- Write latency 1: state updates at the edge where w_en=1. A same-cycle read of the written location returns the old value. The next cycle returns the new value.
- gpio_out changes at the write edge.
- Counter: at edge k after reset release, CYCLE_LO reads k.
- irq timing: counter[31:0]==TIMECMP during cycle n -> irq=1 from edge n+1.
- TIMECMP write in the same cycle as a match: the write wins. irq=0 after the edge, and the match is evaluated against the new value from the next cycle on.
- STATUS clear of err: err=0 after the edge. Only one access per cycle, so a clear cannot coincide with a new error.
- No handshake and no stalls: the responder accepts one access every cycle.

## Test plan
- Reset, then write 0xDEAD_BEEF to 0x0000_0010 -> the same-cycle read of 0x10 returns the old value; the next cycle returns 0xDEAD_BEEF. gpio_out=0, irq=0, err=0 throughout.
- Back-to-back writes to 0x0, 0x4, 0x8 in consecutive cycles, then reads -> each word returns its value. A write to 0x0 followed by reading 0x2 returns the 0x0 word; err stays 0.
- Write 0x1234 to 0x0000_0002, then to DEPTH*4, then to 0x8000_0000 -> all three are dropped. err=1 after the first; STATUS reads 0x2. Writing 0x2 to STATUS clears err to 0 next cycle.
- Write TIMECMP=20 at cycle 5 -> irq rises at edge 21 and stays high. Writing TIMECMP=0xFFFF_FFFF clears irq at that edge.
- Arrange a TIMECMP write in the exact cycle counter[31:0]==TIMECMP -> irq stays 0.
- Write 0x1FF to GPIO (GPIO_W=8) -> gpio_out=0xFF next edge and GPIO reads 0xFF. Then assert rst_n low asynchronously between edges -> gpio_out, irq, err and counter clear immediately, while RAM at 0x10 still holds 0xDEAD_BEEF.
